subneg_control: RTL and testbench
=================================

SUBNEG_CONTROL -- requirements
Module: subneg_control

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, which sets the data, address and PC width.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset (0 = reset) sampled on rising clk.
REQ-004 The block SHALL have port start, input, 1 bit: run request, honoured only in IDLE.
REQ-005 The block SHALL have port mem_addr, output, WIDTH bits: memory address.
REQ-006 The block SHALL have port mem_re, output, 1 bit: read strobe; data returns on mem_rdata exactly 1 cycle later.
REQ-007 The block SHALL have port mem_rdata, input, WIDTH bits: read data.
REQ-008 The block SHALL have port mem_we, output, 1 bit: write strobe; memory writes mem_wdata at mem_addr on that edge.
REQ-009 The block SHALL have port mem_wdata, output, WIDTH bits: write data.
REQ-010 The block SHALL have port pc, output, WIDTH bits: current program counter.
REQ-011 The block SHALL have port busy, output, 1 bit: high in every state except IDLE and HALT.
REQ-012 The block SHALL have port halted, output, 1 bit: high in HALT.

Function
REQ-013 The block SHALL sequence one SUBNEG instruction (A,B,C at pc,pc+1,pc+2): mem[B] <= mem[B] - mem[A]; if result negative pc <= C, else pc <= pc+3.
REQ-014 The block SHALL implement states IDLE, FA, FB, FC, RA, RB, EX, HALT.
REQ-015 State transitions SHALL be: IDLE->FA when start=1; FA->FB->FC->RA->RB->EX unconditionally; EX->FA; EX->HALT when the branch is taken and C equals all-ones; HALT->HALT.
REQ-016 Memory outputs SHALL be Moore decodes: FA addr=pc; FB addr=pc+1; FC addr=pc+2; RA addr=A; RB addr=B; mem_re=1 in FA..RB only.
REQ-017 Internal registers SHALL capture mem_rdata as follows: FB captures A, FC captures B, RA captures C, RB captures opA.
REQ-018 In EX, the block SHALL drive diff = mem_rdata - opA modulo 2^WIDTH, with mem_addr=B, mem_wdata=diff and mem_we=1 for exactly that one cycle.
REQ-019 Negative SHALL mean diff[WIDTH-1]=1; zero SHALL be non-negative and fall through.
REQ-020 pc+1, pc+2 and pc+3 SHALL wrap modulo 2^WIDTH.
REQ-021 Instruction latency SHALL be 6 cycles; pc updates on the EX edge.
REQ-022 In IDLE and HALT, the block SHALL drive mem_re=0, mem_we=0, mem_addr=pc and mem_wdata=0.
REQ-023 start outside IDLE SHALL be ignored; HALT SHALL exit only via reset.

Reset
REQ-024 reset=0 SHALL force state IDLE, pc=0, A=B=C=opA=0 on the next rising edge, regardless of state.
REQ-025 Reset outputs SHALL be mem_addr=0, mem_re=0, mem_we=0, mem_wdata=0, busy=0, halted=0.
REQ-026 Reset asserted during any state including EX SHALL abort the instruction with no write after the reset edge, and SHALL leave pc=0.

Configuration
REQ-027 With macro SUBNEG_ICOUNT_EN defined, the block SHALL add output icount[15:0], incremented on every EX edge, saturating at 0xFFFF, reset to 0.
REQ-028 Without SUBNEG_ICOUNT_EN defined, port icount and its logic SHALL be absent, with all other behaviour identical.

Verification
REQ-029 Branch taken: mem[0..2]=10,11,20, mem[0x10]=5, mem[0x11]=3, start pulse -> after 6 cycles mem[0x11]=0xFE, pc=0x20, mem_we high exactly 1 cycle.
REQ-030 Fall-through: mem[0x10]=3, mem[0x11]=5 -> mem[0x11]=0x02, pc=0x03.
REQ-031 Zero result: mem[0x10]=mem[0x11]=7 -> mem[0x11]=0, pc=0x03 (no branch).
REQ-032 Halt: C=0xFF with negative result -> halted=1, busy=0, mem_re/mem_we stay 0, and start pulses are ignored.
REQ-033 Reset mid-op: reset=0 during RB -> next cycle IDLE, pc=0, mem_we never asserted, mem[B] unchanged.
REQ-034 With SUBNEG_ICOUNT_EN: two non-halting instructions -> icount=2; preset count 0xFFFF plus one more EX -> icount stays 0xFFFF.

Source files
------------

// File: rtl/subneg_control.sv
// SUBNEG sequencer: fetches A,B,C, computes mem[B] -= mem[A], branches to C when negative.
// Define SUBNEG_ICOUNT_EN to add a saturating 16-bit executed-instruction counter (icount).
module subneg_control #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic [WIDTH-1:0] mem_addr,
    output logic             mem_re,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_wdata,
    output logic [WIDTH-1:0] pc,
    output logic             busy,
    output logic             halted
`ifdef SUBNEG_ICOUNT_EN
    ,
    output logic [15:0]      icount
`endif
);

    typedef enum logic [2:0] {
        S_IDLE, S_FA, S_FB, S_FC, S_RA, S_RB, S_EX, S_HALT
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] c_q, c_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] diff;

    assign diff = mem_rdata - opa_q;
    assign pc   = pc_q;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        a_d       = a_q;
        b_d       = b_q;
        c_d       = c_q;
        opa_d     = opa_q;
        mem_addr  = pc_q;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        busy      = 1'b0;
        halted    = 1'b0;
        // Each fetch state captures the data requested by the previous state.
        unique case (state_q)
            S_IDLE: begin
                if (start) state_d = S_FA;
            end
            S_FA: begin
                busy    = 1'b1;
                mem_re  = 1'b1;
                state_d = S_FB;
            end
            S_FB: begin
                busy     = 1'b1;
                mem_re   = 1'b1;
                mem_addr = pc_q + WIDTH'(1);
                a_d      = mem_rdata;
                state_d  = S_FC;
            end
            S_FC: begin
                busy     = 1'b1;
                mem_re   = 1'b1;
                mem_addr = pc_q + WIDTH'(2);
                b_d      = mem_rdata;
                state_d  = S_RA;
            end
            S_RA: begin
                busy     = 1'b1;
                mem_re   = 1'b1;
                mem_addr = a_q;
                c_d      = mem_rdata;
                state_d  = S_RB;
            end
            S_RB: begin
                busy     = 1'b1;
                mem_re   = 1'b1;
                mem_addr = b_q;
                opa_d    = mem_rdata;
                state_d  = S_EX;
            end
            S_EX: begin
                busy      = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = b_q;
                mem_wdata = diff;
                if (diff[WIDTH-1]) begin
                    pc_d    = c_q;
                    state_d = (c_q == '1) ? S_HALT : S_FA;
                end else begin
                    pc_d    = pc_q + WIDTH'(3);
                    state_d = S_FA;
                end
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            opa_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            opa_q   <= opa_d;
        end
    end

`ifdef SUBNEG_ICOUNT_EN
    logic [15:0] icount_q, icount_d;

    always_comb begin
        icount_d = icount_q;
        if (state_q == S_EX && icount_q != 16'hFFFF) icount_d = icount_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!reset) icount_q <= '0;
        else        icount_q <= icount_d;
    end

    assign icount = icount_q;
`endif

endmodule

// File: tb/tb_subneg_control.sv
// Directed bench for subneg_control with a 1-cycle-read behavioural memory.
module tb_subneg_control;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] mem_addr;
    logic       mem_re;
    logic [7:0] mem_rdata = '0;
    logic       mem_we;
    logic [7:0] mem_wdata;
    logic [7:0] pc;
    logic       busy;
    logic       halted;
`ifdef SUBNEG_ICOUNT_EN
    logic [15:0] icount;
`endif

    logic [7:0] mem [256];
    int tests_run = 0;
    int tests_failed = 0;

    subneg_control #(.WIDTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .mem_addr  (mem_addr),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .pc        (pc),
        .busy      (busy),
        .halted    (halted)
`ifdef SUBNEG_ICOUNT_EN
        ,
        .icount    (icount)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] = mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic load_prog(input logic [7:0] a, b, c, va, vb);
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[0] = a;
        mem[1] = b;
        mem[2] = c;
        mem[a] = va;
        mem[b] = vb;
    endtask

    // Resets, runs one instruction from pc=0 and returns at the negedge after the EX edge.
    task automatic run_instr(input logic [7:0] a, b, c, va, vb, exp_res, exp_pc);
        int we_cnt;
        do_reset();
        load_prog(a, b, c, va, vb);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        we_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (i == 0) check("fa_addr", mem_addr, 0);
            if (i == 3) check("ra_addr", mem_addr, a);
            if (mem_we) we_cnt++;
            if (i == 5) begin
                check("ex_addr", mem_addr, b);
                check("ex_wdata", mem_wdata, exp_res);
            end
            @(negedge clk);
        end
        check("result", mem[b], exp_res);
        check("pc", pc, exp_pc);
        check("we_cycles", we_cnt, 1);
    endtask

    initial begin
        int cnt;
        reset = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_addr", mem_addr, 0);
        check("rst_re", mem_re, 0);
        check("rst_we", mem_we, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_busy", busy, 0);
        check("rst_halted", halted, 0);
        check("rst_pc", pc, 0);

        // Branch taken: 3 - 5 = 0xFE, pc <= 0x20
        run_instr(8'h10, 8'h11, 8'h20, 8'd5, 8'd3, 8'hFE, 8'h20);
        check("taken_busy", busy, 1);
        // Fall-through: 5 - 3 = 2
        run_instr(8'h10, 8'h11, 8'h20, 8'd3, 8'd5, 8'h02, 8'h03);
        // Zero result is non-negative
        run_instr(8'h10, 8'h11, 8'h20, 8'd7, 8'd7, 8'h00, 8'h03);

        // Branch to 0xFD, then an instruction whose fetches and pc+3 wrap
        run_instr(8'h10, 8'h11, 8'hFD, 8'd5, 8'd3, 8'hFE, 8'hFD);
        mem[8'hFD] = 8'h12;
        mem[8'hFE] = 8'h13;
        mem[8'hFF] = 8'h40;
        mem[8'h12] = 8'd1;
        mem[8'h13] = 8'd4;
        repeat (6) @(negedge clk);
        check("wrap_result", mem[8'h13], 8'h03);
        check("wrap_pc", pc, 8'h00);

        // Halt: negative result with C = 0xFF
        run_instr(8'h10, 8'h11, 8'hFF, 8'd5, 8'd3, 8'hFE, 8'hFF);
        check("halt_halted", halted, 1);
        check("halt_busy", busy, 0);
        check("halt_addr", mem_addr, 8'hFF);
        cnt = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) begin
            if (mem_re || mem_we) cnt++;
            @(negedge clk);
        end
        check("halt_strobes", cnt, 0);
        check("halt_stays", halted, 1);
        check("halt_pc", pc, 8'hFF);

        // Reset during RB aborts with no write
        do_reset();
        load_prog(8'h10, 8'h11, 8'h20, 8'd5, 8'd3);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cnt = 0;
        repeat (4) begin
            if (mem_we) cnt++;
            @(negedge clk);
        end
        check("rb_busy", busy, 1);
        check("rb_addr", mem_addr, 8'h11);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("abort_busy", busy, 0);
        check("abort_pc", pc, 0);
        check("abort_addr", mem_addr, 0);
        repeat (4) begin
            if (mem_we) cnt++;
            @(negedge clk);
        end
        check("abort_we", cnt, 0);
        check("abort_mem", mem[8'h11], 8'd3);
        check("abort_idle", busy, 0);

`ifdef SUBNEG_ICOUNT_EN
        run_instr(8'h10, 8'h11, 8'h20, 8'd3, 8'd5, 8'h02, 8'h03);
        check("icount_one", icount, 1);
        mem[3] = 8'h10;
        mem[4] = 8'h12;
        mem[5] = 8'h20;
        mem[8'h12] = 8'd9;
        repeat (6) @(negedge clk);
        check("icount_two", icount, 2);
        check("icount_res", mem[8'h12], 8'd6);
        dut.icount_q = 16'hFFFF;
        repeat (6) @(negedge clk);
        check("icount_sat", icount, 16'hFFFF);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
